fetch_decode_queue: RTL
=======================

# fetch_decode_queue

Parametrised successor to the single-entry IF/ID register. It buffers up to DEPTH fetched instructions together with their PCs between the fetch stage and the decoder. The queue decouples i_cache latency from decode stalls, injects a NOP bubble when empty or flushed, and flags misaligned fetch PCs. It sits between the fetch-stage i_cache output and the decode-stage register file/control logic.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, ≥2
- BUBBLE_INSTR, 32'h0000_0013, instruction driven when no valid entry (addi x0,x0,0)
- Width of PC/instruction is rv32i_pkg::DPW (32); CNTW = $clog2(DEPTH+1)

Ports (clock and reset first):
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- PCF  in  DPW  PC of the fetched instruction
- instrF  in  DPW  fetched instruction from i_cache
- validF  in  1  instrF/PCF valid this cycle
- readyF  out  DPW→1  queue can accept (count < DEPTH)
- flushD  in  1  discard all entries (branch/jump redirect)
- stallD  in  1  decode holds current head
- instrD  out  DPW  head instruction, or BUBBLE_INSTR when validD=0
- PCD  out  DPW  head PC, or 0 when validD=0
- validD  out  1  head entry valid
- misalignD  out  1  head PC has PC[1:0]≠0 (0 when validD=0)
- count  out  CNTW  occupied entries, 0..DEPTH

## Operation
- Storage: DEPTH entries of {PC, instr, misalign}; wr_ptr, rd_ptr of $clog2(DEPTH) bits wrap modulo DEPTH; count tracked separately.
- Push: validF && readyF → write entry at wr_ptr, wr_ptr+1.
- Pop: validD && !stallD → rd_ptr+1.
- Push and pop in the same cycle: both happen, count is unchanged.
- readyF depends on count only, not on same-cycle pop: when full, pushes are refused even if popping.
- validF while readyF=0: entry dropped; the fetch stage must hold PCF and re-present it.
- Flush: highest priority. Pointers and count go to 0, all entries are invalidated, and a same-cycle push or pop is ignored. stallD is irrelevant during flush.
- Outputs are combinational from registered head storage only; no combinational path from any input to any output.
- misalign is computed at push as PCF[1:0]≠0 and stored with the entry.
- Empty: validD=0, instrD=BUBBLE_INSTR, PCD=0, misalignD=0.

## Timing
- Latency: an instruction pushed in cycle N is visible on instrD/PCD/validD in cycle N+1 when the queue was empty. There is no same-cycle bypass.
- Throughput: 1 push and 1 pop per cycle sustained.
- Flush asserted in cycle N: validD=0 and count=0 from cycle N+1. A push in cycle N+1 is visible in N+2.
- Reset, async assert at any time, including mid-operation: pointers=0, count=0, validD=0, instrD=BUBBLE_INSTR, PCD=0, misalignD=0, readyF=1. Contents are discarded. Release is synchronous to clk by the external reset synchroniser.
- Wrap: pointers roll from DEPTH-1 to 0 with no bubble.
- Full (count=DEPTH): readyF=0 from the same cycle count reaches DEPTH.

## Structure
- rv32i_pkg gains NOP_INSTR = 32'h0000_0013 (BUBBLE_INSTR default) and typedef fdq_entry_t {logic [DPW-1:0] pc; logic [DPW-1:0] instr; logic misalign;}.
- One sub-module: fdq_ptr, a parametrised wrap-around pointer with increment and clear. It is instantiated twice (read and write).
- i_cache stays outside. The fetch stage instantiates it and feeds instrF/PCF.

## Test plan
- Reset then push 0x00500093@PC 0x0 → next cycle validD=1, instrD=0x00500093, PCD=0, count=1.
- Push 4 entries with stallD=1, DEPTH=4 → count=4, readyF=0. A 5th push is dropped. Release stall → 4 pops in order, PCs 0,4,8,C.
- Simultaneous push and pop at count=2 for 10 cycles → count stays 2, order preserved across pointer wrap.
- Full queue with flushD=1 and validF=1 in the same cycle → next cycle count=0, validD=0, instrD=0x00000013, PCD=0. Pushed entry absent.
- Push PC 0x6 → misalignD=1 at head. Pop it → misalignD=0 when empty.
- Assert rst_n=0 mid-stream with count=3 → outputs take reset values immediately, without waiting for clk. After release, the first push appears after 1 cycle.

Source files
------------

// File: rtl/rv32i_pkg.sv
// ----------------------------------------------------------------------------
// rv32i_pkg
// Shared RV32I datapath definitions used by the fetch/decode front end.
//   DPW         : width of PCs and instruction words
//   NOP_INSTR   : canonical bubble, addi x0,x0,0
//   fdq_entry_t : one fetch/decode queue slot {pc, instr, misalign}
// ----------------------------------------------------------------------------
package rv32i_pkg;

    localparam int DPW = 32;

    localparam logic [DPW-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [DPW-1:0] pc;
        logic [DPW-1:0] instr;
        logic           misalign;
    } fdq_entry_t;

endpackage

// File: rtl/fdq_ptr.sv
// ----------------------------------------------------------------------------
// fdq_ptr
// Wrap-around pointer for the fetch/decode queue. Rolls from 2**PTRW-1 to 0,
// so the queue depth must be a power of two. Clear wins over increment.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : return pointer to 0
//   inc_i      : advance pointer by one
//   ptr_o      : current pointer value
// ----------------------------------------------------------------------------
module fdq_ptr #(
    parameter int PTRW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            inc_i,
    output logic [PTRW-1:0] ptr_o
);

    logic [PTRW-1:0] ptr_q;
    logic [PTRW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + PTRW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fetch_decode_queue.sv
// ----------------------------------------------------------------------------
// fetch_decode_queue
// DEPTH-entry FIFO between the fetch stage (i_cache output) and decode.
// Replaces the single IF/ID register; drives a NOP bubble when empty.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   PCF, instrF     : fetched PC / instruction
//   validF          : fetch data valid; dropped when readyF=0
//   readyF          : queue not full (depends on count only)
//   flushD          : discard all entries (redirect), highest priority
//   stallD          : decode holds the head entry
//   instrD, PCD     : head instruction / PC (bubble / 0 when empty)
//   validD          : head entry valid
//   misalignD       : head PC[1:0] != 0
//   count           : occupied entries, 0..DEPTH
// ----------------------------------------------------------------------------
module fetch_decode_queue
    import rv32i_pkg::*;
#(
    parameter int             DEPTH        = 4,
    parameter logic [DPW-1:0] BUBBLE_INSTR = NOP_INSTR,
    parameter int             CNTW         = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DPW-1:0]  PCF,
    input  logic [DPW-1:0]  instrF,
    input  logic            validF,
    output logic            readyF,
    input  logic            flushD,
    input  logic            stallD,
    output logic [DPW-1:0]  instrD,
    output logic [DPW-1:0]  PCD,
    output logic            validD,
    output logic            misalignD,
    output logic [CNTW-1:0] count
);

    localparam int              PTRW     = $clog2(DEPTH);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

    fdq_entry_t      mem_q [DEPTH];
    logic [CNTW-1:0] count_q;
    logic [CNTW-1:0] count_d;
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic            push;
    logic            pop;
    fdq_entry_t      head;

    // readyF looks only at the registered count, so a full queue refuses a
    // push even when decode pops in the same cycle.
    assign readyF = (count_q != FULL_CNT);
    assign validD = (count_q != '0);

    // Flush suppresses both sides so that nothing survives a redirect.
    assign push = validF && readyF && !flushD;
    assign pop  = validD && !stallD && !flushD;

    always_comb begin
        count_d = count_q;
        if (flushD) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNTW'(push) - CNTW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset: empty slots are never observable
    // because every output is gated by validD.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr] <= '{pc: PCF, instr: instrF, misalign: (PCF[1:0] != 2'b00)};
        end
    end

    fdq_ptr #(.PTRW(PTRW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (flushD),
        .inc_i (push),
        .ptr_o (wr_ptr)
    );

    fdq_ptr #(.PTRW(PTRW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (flushD),
        .inc_i (pop),
        .ptr_o (rd_ptr)
    );

    assign head      = mem_q[rd_ptr];
    assign instrD    = validD ? head.instr : BUBBLE_INSTR;
    assign PCD       = validD ? head.pc    : '0;
    assign misalignD = validD && head.misalign;
    assign count     = count_q;

endmodule
